scanner_link_tx: RTL and testbench
==================================

Name: scanner_link_tx

Overview:
- Scanner-side serial transmitter for the scanner-to-transfer-center link.
- Turns buffer-fill threshold crossings into status codes, and host data bytes into header+data frame pairs.
- Serializes everything MSB-first in fixed 8-cycle slots on a single data wire that drives the transfer center's serial input.
- Slot timing is free-running from reset; both ends leave reset in the same cycle, so slots are aligned.

Parameters:
TH_HALF, 50, fill_pct threshold for code 8'd1
TH_80, 80, threshold for code 8'd2
TH_90, 90, threshold for code 8'd3
TH_FULL, 100, threshold for code 8'd4
IDLE_CODE, 8'd0, byte sent in empty slots; must not be 1,2,3,4,7 or 8

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fill_pct  in  7  scanner buffer fill, percent; values >100 count as at/above every threshold
tx_valid  in  1  host data byte available
tx_data  in  8  host data byte
tx_ascii  in  1  1: header 8'd8 (ASCII); 0: header 8'd7 (binary); sampled with tx_data
peer_ready  in  1  transfer center ready-for-transfer; gates new data frames only
tx_ready  out  1  accept strobe; transfer occurs when tx_valid & tx_ready
serial_out  out  1  serial line, MSB first
slot_start  out  1  high while bit 7 (MSB) of a slot is on serial_out
busy  out  1  state != S_IDLE or any status pending

Behaviour:
- Reset (synchronous):
  - bit_cnt=0, state=S_IDLE, shift register=IDLE_CODE.
  - All four thresholds armed, pending=0.
  - Outputs: serial_out=IDLE_CODE[7], slot_start=1, tx_ready=0, busy=0.
- Slot timing:
  - bit_cnt is 3 bits and wraps 7->0 every cycle with no stall.
  - serial_out = shreg[7]; shreg shifts left each cycle.
  - At bit_cnt==7 the next slot's byte loads, so its MSB appears in the cycle where bit_cnt==0.
  - slot_start = (bit_cnt==0).
- Threshold tracking, per threshold, every cycle:
  - If armed and fill_pct >= TH: set pending, clear armed.
  - If fill_pct < TH: re-arm. This never clears an already-pending flag.
  - Several thresholds may cross in one cycle; all become pending.
- States (the state names the slot currently on the wire): S_IDLE, S_STATUS, S_HDR, S_DATA.
- Slot decision at bit_cnt==7, first match wins:
  1. state==S_HDR -> S_DATA; load the latched byte. A frame pair is atomic, so status never splits it.
  2. Any pending -> S_STATUS; load the code of the lowest pending threshold (1 before 2 before 3 before 4) and clear that pending bit. Remaining codes go out one per slot in later slots.
  3. tx_valid & peer_ready -> S_HDR; load 8'd8 or 8'd7 per tx_ascii; latch tx_data.
  4. Otherwise -> S_IDLE; load IDLE_CODE.
- tx_ready:
  - Combinational: (bit_cnt==7) & (state!=S_HDR) & (pending==0) & peer_ready.
  - tx_ready is high for at most one cycle per slot.
  - Acceptance is exactly rule 3; the host holds tx_valid/tx_data until it sees the strobe.
- peer_ready:
  - Dropping it never aborts an S_DATA slot already committed.
  - Status codes are sent regardless of peer_ready.
- Latency:
  - A fill_pct crossing sampled at cycle t sets pending at t+1.
  - The code's MSB appears 1-8 cycles after that, at the next slot boundary.
  - Data byte MSB appears 9 cycles after acceptance; the header occupies the 8 intervening cycles.
- Reset mid-slot: the partial byte is abandoned, the serial line restarts with IDLE_CODE at bit_cnt=0, the latched data is discarded and all thresholds re-arm.

Optional Feature:
- Macro: SCAN_TX_FULL_REPEAT_EN.
- Defined:
  - While fill_pct >= TH_FULL, a 4-bit slot counter, cleared on each code-4 send, re-raises pending code 4 after 16 further slots with no code-4 send.
  - The counter clears when fill_pct drops below TH_FULL.
  - This gives a periodic full reminder; priority is unchanged.
- Undefined: code 4 is sent once per upward crossing only.

Test Plan:
- Reset release with fill_pct=0, tx_valid=0 -> serial_out carries 8'h00 every slot; slot_start every 8th cycle starting cycle 0; busy=0.
- fill_pct 40->55 held -> exactly one 8'h01 slot (0000_0001 MSB-first), then idle; 55->40->55 -> a second 8'h01.
- fill_pct 0->95 in one cycle -> consecutive slots 8'h01, 8'h02, 8'h03; 8'h04 never sent.
- tx_valid=1, tx_data=8'hA5, tx_ascii=0, peer_ready=1 -> tx_ready pulses once at bit_cnt 7; next two slots 8'h07 then 8'hA5; tx_ascii=1 gives 8'h08 then 8'hA5.
- fill_pct crosses 50 during an 8'h07 header slot -> header, 8'hA5, then 8'h01 (pair never split); with peer_ready=0 and tx_valid=1 -> tx_ready stays 0, idle bytes only.
- Assert rst at bit_cnt 4 of a data slot -> next cycle serial_out=0, slot_start=1, pending cleared; host byte not resent unless re-offered.

Source files
------------

// File: rtl/scanner_link_tx.sv
// rtl/scanner_link_tx.sv - scanner-to-transfer-center serial transmitter (optional: SCAN_TX_FULL_REPEAT_EN)
// Fixed 8-cycle MSB-first slots carrying threshold status codes and header+data frame pairs.
module scanner_link_tx #(
    parameter int         TH_HALF   = 50,
    parameter int         TH_80     = 80,
    parameter int         TH_90     = 90,
    parameter int         TH_FULL   = 100,
    parameter logic [7:0] IDLE_CODE = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] fill_pct,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_ascii,
    input  logic       peer_ready,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       slot_start,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATUS,
        S_HDR,
        S_DATA
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic [3:0] armed_q, armed_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] pend_clr;
    logic [3:0] pend_rep;
    logic [3:0] at_th;
    logic       slot_end;

    assign at_th[0] = ({1'b0, fill_pct} >= 8'(TH_HALF));
    assign at_th[1] = ({1'b0, fill_pct} >= 8'(TH_80));
    assign at_th[2] = ({1'b0, fill_pct} >= 8'(TH_90));
    assign at_th[3] = ({1'b0, fill_pct} >= 8'(TH_FULL));

    assign slot_end   = (bit_cnt_q == 3'd7);
    assign tx_ready   = slot_end && (state_q != S_HDR) && (pend_q == 4'd0) && peer_ready;
    assign serial_out = shreg_q[7];
    assign slot_start = (bit_cnt_q == 3'd0);
    assign busy       = (state_q != S_IDLE) || (pend_q != 4'd0);

    always_comb begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shreg_d   = {shreg_q[6:0], 1'b0};
        state_d   = state_q;
        data_d    = data_q;
        pend_clr  = 4'd0;
        if (slot_end) begin
            if (state_q == S_HDR) begin
                state_d = S_DATA;
                shreg_d = data_q;
            end else if (pend_q != 4'd0) begin
                state_d = S_STATUS;
                if (pend_q[0]) begin
                    shreg_d     = 8'd1;
                    pend_clr[0] = 1'b1;
                end else if (pend_q[1]) begin
                    shreg_d     = 8'd2;
                    pend_clr[1] = 1'b1;
                end else if (pend_q[2]) begin
                    shreg_d     = 8'd3;
                    pend_clr[2] = 1'b1;
                end else begin
                    shreg_d     = 8'd4;
                    pend_clr[3] = 1'b1;
                end
            end else if (tx_valid && tx_ready) begin
                state_d = S_HDR;
                shreg_d = tx_ascii ? 8'd8 : 8'd7;
                data_d  = tx_data;
            end else begin
                state_d = S_IDLE;
                shreg_d = IDLE_CODE;
            end
        end
        // A threshold is armed exactly when the fill is below it; pending latches on armed crossings.
        armed_d = ~at_th;
        pend_d  = (pend_q & ~pend_clr) | (armed_q & at_th) | pend_rep;
    end

`ifdef SCAN_TX_FULL_REPEAT_EN
    logic [3:0] rep_q, rep_d;

    always_comb begin
        rep_d    = rep_q;
        pend_rep = 4'd0;
        if (!at_th[3]) begin
            rep_d = 4'd0;
        end else if (slot_end) begin
            if (pend_clr[3]) begin
                rep_d = 4'd0;
            end else if (rep_q == 4'd15) begin
                rep_d       = 4'd0;
                pend_rep[3] = 1'b1;
            end else begin
                rep_d = rep_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= 4'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign pend_rep = 4'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            state_q   <= S_IDLE;
            shreg_q   <= IDLE_CODE;
            data_q    <= 8'd0;
            armed_q   <= 4'hF;
            pend_q    <= 4'd0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            armed_q   <= armed_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_scanner_link_tx.sv
// tb/tb_scanner_link_tx.sv - slot-level model compared every cycle plus directed byte-sequence expectations
module tb_scanner_link_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] fill_pct = 7'd0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ascii = 1'b0;
    logic       peer_ready = 1'b1;
    logic       tx_ready, serial_out, slot_start, busy;

    scanner_link_tx dut (
        .clk        (clk),
        .rst        (rst),
        .fill_pct   (fill_pct),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ascii   (tx_ascii),
        .peer_ready (peer_ready),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .slot_start (slot_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Model: position within slot, the byte the current slot carries, and what kind of slot it is.
    int         m_pos;
    logic [7:0] m_byte;
    logic [7:0] m_data;
    int         m_kind;   // 0 idle, 1 status, 2 header, 3 data
    bit   [3:0] m_arm;
    bit   [3:0] m_pend;
    int         m_rep;
    bit         started = 1'b0;
    int         th [4] = '{50, 80, 90, 100};

    initial begin
        bit found;
        bit sent4;
        forever begin
            @(posedge clk);
            started = 1'b1;
            if (rst) begin
                m_pos = 0; m_byte = 8'h00; m_kind = 0;
                m_arm = 4'hF; m_pend = 4'h0; m_rep = 0;
            end else begin
                sent4 = 1'b0;
                if (m_pos == 7) begin
                    if (m_kind == 2) begin
                        m_kind = 3; m_byte = m_data;
                    end else if (m_pend != 0) begin
                        m_kind = 1; found = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            if (!found && m_pend[i]) begin
                                found = 1'b1; m_pend[i] = 1'b0;
                                m_byte = 8'(i + 1);
                                if (i == 3) sent4 = 1'b1;
                            end
                        end
                    end else if (tx_valid && peer_ready) begin
                        m_kind = 2; m_byte = tx_ascii ? 8'h08 : 8'h07; m_data = tx_data;
                    end else begin
                        m_kind = 0; m_byte = 8'h00;
                    end
                end
`ifdef SCAN_TX_FULL_REPEAT_EN
                if (int'(fill_pct) < 100) m_rep = 0;
                else if (m_pos == 7) begin
                    if (sent4) m_rep = 0;
                    else if (m_rep == 15) begin m_rep = 0; m_pend[3] = 1'b1; end
                    else m_rep++;
                end
`endif
                for (int i = 0; i < 4; i++) begin
                    if (int'(fill_pct) >= th[i]) begin
                        if (m_arm[i]) m_pend[i] = 1'b1;
                        m_arm[i] = 1'b0;
                    end else begin
                        m_arm[i] = 1'b1;
                    end
                end
                m_pos = (m_pos + 1) % 8;
            end
        end
    end

    logic [7:0] cap = 8'h00;
    logic [7:0] rx_q [$];
    int         rdy_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("serial_out", int'(serial_out), int'(m_byte[7 - m_pos]));
                check("slot_start", int'(slot_start), int'(m_pos == 0));
                check("tx_ready", int'(tx_ready),
                      int'(m_pos == 7 && m_kind != 2 && m_pend == 0 && peer_ready));
                check("busy", int'(busy), int'(m_kind != 0 || m_pend != 0));
                cap = {cap[6:0], serial_out};
                if (m_pos == 7) rx_q.push_back(cap);
                if (tx_ready && tx_valid) rdy_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input string name, input int n_exp, input logic [31:0] s_exp);
        int          n = 0;
        logic [31:0] s = 32'h0;
        foreach (rx_q[i]) begin
            if (rx_q[i] != 8'h00) begin
                if (n < 4) s = {s[23:0], rx_q[i]};
                n++;
            end
        end
        check({name, "_count"}, n, n_exp);
        check(name, int'(s), int'(s_exp));
    endtask

    task automatic send_frame(input logic [7:0] d, input logic a);
        bit ok = 1'b0;
        tx_data = d; tx_ascii = a; tx_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (tx_ready) begin ok = 1'b1; break; end
        end
        check("accept_seen", int'(ok), 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("reset_serial", int'(serial_out), 0);
        check("reset_slot_start", int'(slot_start), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_ready", int'(tx_ready), 0);

        rx_q.delete();
        tick(32);
        check("idle_slot_count", int'(rx_q.size() >= 3), 1);
        expect_seq("idle", 0, 32'h0);

        fill_pct = 7'd40; tick(8);
        rx_q.delete(); fill_pct = 7'd55; tick(40);
        expect_seq("half_once", 1, 32'h01);
        fill_pct = 7'd40; tick(2);
        rx_q.delete(); fill_pct = 7'd50; tick(40);
        expect_seq("half_again_eq50", 1, 32'h01);

        fill_pct = 7'd0; tick(8);
        rx_q.delete(); fill_pct = 7'd95; tick(48);
        expect_seq("jump95", 3, 32'h010203);
        fill_pct = 7'd0; tick(8);
        rx_q.delete(); fill_pct = 7'd120; tick(56);
        expect_seq("over100", 4, 32'h01020304);
        fill_pct = 7'd0; tick(8);

        rx_q.delete(); rdy_cnt = 0;
        send_frame(8'hA5, 1'b0); tick(24);
        expect_seq("bin_frame", 2, 32'h07A5);
        check("bin_ready_once", rdy_cnt, 1);
        rx_q.delete(); rdy_cnt = 0;
        send_frame(8'hA5, 1'b1); tick(24);
        expect_seq("ascii_frame", 2, 32'h08A5);
        check("ascii_ready_once", rdy_cnt, 1);

        fill_pct = 7'd40; tick(8);
        rx_q.delete();
        send_frame(8'hA5, 1'b0);
        tick(2); fill_pct = 7'd55; tick(32);
        expect_seq("pair_atomic", 3, 32'h07A501);

        peer_ready = 1'b0; tx_valid = 1'b1; rdy_cnt = 0;
        rx_q.delete(); tick(32);
        check("peer_block_ready", rdy_cnt, 0);
        expect_seq("peer_block", 0, 32'h0);
        tx_valid = 1'b0; peer_ready = 1'b1;

        fill_pct = 7'd40; tick(8);
        send_frame(8'hA5, 1'b0);
        tick(1); fill_pct = 7'd55; tick(11);
        rst = 1'b1; fill_pct = 7'd0;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_serial", int'(serial_out), 0);
        check("midrst_slot_start", int'(slot_start), 1);
        check("midrst_busy", int'(busy), 0);
        rx_q.delete(); tick(32);
        expect_seq("post_reset", 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
